// File: rtl/sar_conv_sequencer.sv
// Control sequencer for one 16-bit SAR conversion per request: steps the CORDIC phase, strobes the
// sample-and-hold, runs MSB-first bit trials and hands the result out on valid/ready.
// Optional build macro SAR_TIMEOUT_EN adds a bounded wait for sincos_tvalid with a sticky error.
module sar_conv_sequencer #(
    parameter int unsigned WIDTH          = 16,
    parameter logic [15:0] PHASE_INC      = 16'd256,
    parameter logic [15:0] PI_POS         = 16'h6488,
    parameter logic [15:0] PI_NEG         = 16'h9B78,
    parameter int unsigned CORDIC_TIMEOUT = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic [15:0]      phase_o,
    output logic             phase_tvalid_o,
    input  logic             sincos_tvalid_i,
    output logic             sample_hold_o,
    output logic [WIDTH-1:0] dac_code_o,
    input  logic             comparator_out_i,
    output logic [WIDTH-1:0] digital_out_o,
    output logic             data_valid_o,
    input  logic             data_ready_i,
    output logic             busy_o,
    output logic             timeout_err_o
);

    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StPhase,
        StWait,
        StSample,
        StConvert,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       phase_q, phase_d;
    logic [WIDTH-1:0]  trial_q, trial_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [WIDTH-1:0]  dac_hold_q, dac_hold_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  bit_mask;
    logic signed [16:0] phase_sum;

    assign bit_mask  = {{(WIDTH-1){1'b0}}, 1'b1} << idx_q;
    // 17-bit signed sum so the +pi comparison cannot overflow
    assign phase_sum = $signed({phase_q[15], phase_q}) + $signed({PHASE_INC[15], PHASE_INC});

`ifdef SAR_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(CORDIC_TIMEOUT + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^CORDIC_TIMEOUT;
`endif

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        trial_d    = trial_q;
        result_d   = result_q;
        dac_hold_d = dac_hold_q;
        idx_d      = idx_q;
        dac_code_o = '0;
`ifdef SAR_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StPhase;
            end
            StPhase: begin
                state_d = StWait;
`ifdef SAR_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            StWait: begin
                if (sincos_tvalid_i) begin
                    state_d = StSample;
`ifdef SAR_TIMEOUT_EN
                end else if (cnt_q == CntW'(CORDIC_TIMEOUT - 1)) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
`endif
                end
            end
            StSample: begin
                dac_code_o = {1'b1, {(WIDTH-1){1'b0}}};
                trial_d    = '0;
                idx_d      = IdxW'(WIDTH - 1);
                state_d    = StConvert;
            end
            StConvert: begin
                dac_code_o     = trial_q | bit_mask;
                trial_d[idx_q] = comparator_out_i;
                if (idx_q == '0) begin
                    result_d   = trial_d;
                    dac_hold_d = dac_code_o;
                    state_d    = StDone;
                end else begin
                    idx_d = idx_q - IdxW'(1);
                end
            end
            StDone: begin
                dac_code_o = dac_hold_q;
                if (data_ready_i) begin
                    state_d = StIdle;
                    if (phase_sum < $signed({PI_POS[15], PI_POS})) phase_d = phase_sum[15:0];
                    else                                            phase_d = PI_NEG;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            trial_q    <= '0;
            result_q   <= '0;
            dac_hold_q <= '0;
            idx_q      <= '0;
`ifdef SAR_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            trial_q    <= trial_d;
            result_q   <= result_d;
            dac_hold_q <= dac_hold_d;
            idx_q      <= idx_d;
`ifdef SAR_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign phase_o        = phase_q;
    assign phase_tvalid_o = (state_q == StPhase);
    assign sample_hold_o  = (state_q == StSample);
    assign digital_out_o  = result_q;
    assign data_valid_o   = (state_q == StDone);
    assign busy_o         = (state_q != StIdle);
`ifdef SAR_TIMEOUT_EN
    assign timeout_err_o  = err_q;
`else
    assign timeout_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Randomised bench for sar_conv_sequencer: an ideal held-analog comparator environment plus a
// cycle-occupancy reference model derived from the conversion rules, checked every cycle.
module tb_sar_conv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sincos_tvalid = 1'b0;
    logic        data_ready = 1'b0;
    logic        comparator;
    logic [15:0] phase, dac_code, digital_out;
    logic        phase_tvalid, sample_hold, data_valid, busy, timeout_err;

    int n_pass = 0;
    int n_total = 0;

    // Environment: 0 = random, 1 = always high, 2 = always low
    int          tv_mode = 1;
    int          rdy_mode = 1;
    bit          an_fix_en = 1'b1;
    logic [15:0] an_fix = 16'h8000;
    logic [15:0] analog_in = 16'h0000;
    logic [15:0] held = 16'h0000;

    sar_conv_sequencer dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_i          (start),
        .phase_o          (phase),
        .phase_tvalid_o   (phase_tvalid),
        .sincos_tvalid_i  (sincos_tvalid),
        .sample_hold_o    (sample_hold),
        .dac_code_o       (dac_code),
        .comparator_out_i (comparator),
        .digital_out_o    (digital_out),
        .data_valid_o     (data_valid),
        .data_ready_i     (data_ready),
        .busy_o           (busy),
        .timeout_err_o    (timeout_err)
    );

    always #5 clk = ~clk;

    // Ideal sample-and-hold and comparator
    always @(posedge clk) if (sample_hold) held <= analog_in;
    assign comparator = (held >= dac_code);

    always @(posedge clk) begin
        #1;
        sincos_tvalid = (tv_mode == 1) ? 1'b1 : (tv_mode == 2) ? 1'b0 : ($urandom_range(2) == 0);
        data_ready    = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(1) == 0);
        analog_in     = an_fix_en ? an_fix : 16'($urandom);
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    endtask

    task automatic timeout_fail(input string nm);
        n_total++;
        $display("FAIL %s: no response within cycle budget at %0t", nm, $time);
    endtask

    function automatic logic [15:0] advance(input logic [15:0] p);
        int s;
        logic [31:0] sv;
        s  = int'($signed(p)) + 256;
        sv = s;
        if (s < 25736) return sv[15:0];  // +pi = 0x6488
        return 16'h9B78;
    endfunction

    // Reference model: which cycle of the request/convert/handshake timeline we are in
    bit          m_idle = 1'b1, m_wait = 1'b0, m_sh = 1'b0, m_ptv = 1'b0;
    int          m_k = 0;  // 0 none, 1..16 bit trials (bit 16-k), 17 result pending
    logic        p_start = 1'b0, p_tv = 1'b0, p_rdy = 1'b0;
    logic [15:0] exp_phase = 16'h0000;
    int          hs_count = 0, sh_count = 0;
    logic [15:0] ptv_log[$];
    logic [15:0] dac_log[17];

    always @(negedge clk) begin : mon
        bit          n_ptv, n_idle, n_sh, n_wait;
        int          n_k, i, e;
        logic [31:0] ev;
        if (!rst_n) begin
            m_idle = 1'b1; m_wait = 1'b0; m_sh = 1'b0; m_ptv = 1'b0; m_k = 0;
            p_start = 1'b0; p_tv = 1'b0; p_rdy = 1'b0;
            exp_phase = 16'h0000;
        end else begin
            n_ptv  = m_idle && p_start;
            n_idle = (m_idle && !p_start) || (m_k == 17 && p_rdy);
            n_sh   = m_wait && p_tv;
            n_wait = m_ptv || (m_wait && !p_tv);
            if (m_sh)                      n_k = 1;
            else if (m_k >= 1 && m_k <= 16) n_k = m_k + 1;
            else if (m_k == 17 && !p_rdy)  n_k = 17;
            else                           n_k = 0;
            if (m_k == 17 && p_rdy) begin
                exp_phase = advance(exp_phase);
                hs_count++;
            end

            check("busy", busy, !n_idle);
            check("phase_tvalid", phase_tvalid, n_ptv);
            check("sample_hold", sample_hold, n_sh);
            check("data_valid", data_valid, n_k == 17);
            check("phase", phase, exp_phase);
`ifndef SAR_TIMEOUT_EN
            check("timeout_err", timeout_err, 0);
`endif
            if (n_sh) begin
                check("dac_sample", dac_code, 16'h8000);
                dac_log[0] = dac_code;
            end else if (n_k >= 1 && n_k <= 16) begin
                i  = 16 - n_k;
                e  = (int'(held) & ~((1 << (i + 1)) - 1)) | (1 << i);
                ev = e;
                check("dac_trial", dac_code, {16'h0, ev[15:0]});
                dac_log[n_k] = dac_code;
            end else if (n_k == 0) begin
                check("dac_idle", dac_code, 0);
            end
            if (n_k == 17) check("digital_out", digital_out, held);
            if (sample_hold) sh_count++;
            if (n_ptv) ptv_log.push_back(phase);

            m_idle = n_idle; m_wait = n_wait; m_sh = n_sh; m_ptv = n_ptv; m_k = n_k;
            p_start = start; p_tv = sincos_tvalid; p_rdy = data_ready;
        end
    end

    task automatic wait_idle(input string nm);
        bit ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail(nm);
    endtask

    task automatic run_one(input logic [15:0] v, input string nm);
        bit ok = 1'b0;
        an_fix = v;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (data_valid) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail(nm);
        else     check(nm, digital_out, v);
        wait_idle(nm);
    endtask

    initial begin
        int lat;
        int sh0, hs0, n0;
        bit ok;

        // Reset state
        #3;
        check("rst_phase", phase, 16'h0000);
        check("rst_busy", busy, 0);
        check("rst_valid", data_valid, 0);
        check("rst_dac", dac_code, 16'h0000);
        check("rst_dout", digital_out, 16'h0000);
        check("rst_ptv", phase_tvalid, 0);
        check("rst_sh", sample_hold, 0);
        check("rst_err", timeout_err, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Mid-scale conversion, latency from the start sample edge
        tv_mode = 1; rdy_mode = 1; an_fix_en = 1'b1; an_fix = 16'h8000;
        sh0 = sh_count;
        @(posedge clk); #1 start = 1'b1;
        lat = 0; ok = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            if (data_valid) begin lat = n; ok = 1'b1; break; end
        end
        if (!ok) timeout_fail("t1_valid");
        check("t1_latency", lat, 20);
        check("t1_result", digital_out, 16'h8000);
        wait_idle("t1_idle");
        check("t1_sample_hold_count", sh_count - sh0, 1);

        // Full scale and zero scale
        run_one(16'hFFFF, "t2_ffff");
        run_one(16'h0000, "t2_0000");
        for (int j = 1; j <= 16; j++) check("t2_dac_seq", dac_log[j], 16'h8000 >> (j - 1));

        // Back-to-back random conversions with start held, across the +pi wrap
        an_fix_en = 1'b0; tv_mode = 0; rdy_mode = 0;
        @(posedge clk); #1 start = 1'b1;
        for (int n = 0; n < 10000 && ptv_log.size() < 103; n++) @(negedge clk);
        @(posedge clk); #1 start = 1'b0;
        wait_idle("t3_idle");
        if (ptv_log.size() < 103) timeout_fail("t3_phase_log");
        else begin
            check("t3_phase_3", ptv_log[3], 16'h0300);
            check("t3_phase_100", ptv_log[100], 16'h6400);
            check("t3_phase_101", ptv_log[101], 16'h9B78);
            check("t3_phase_102", ptv_log[102], 16'h9C78);
        end

        // Consumer stall in DONE
        rdy_mode = 2; tv_mode = 1; an_fix_en = 1'b1; an_fix = 16'h1234;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (data_valid) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail("t4_valid");
        n0 = ptv_log.size();
        hs0 = hs_count;
        repeat (10) @(negedge clk);
        check("t4_valid_held", data_valid, 1);
        check("t4_busy_held", busy, 1);
        check("t4_dout_held", digital_out, 16'h1234);
        check("t4_no_ptv", ptv_log.size(), n0);
        rdy_mode = 1;
        wait_idle("t4_idle");
        repeat (3) @(negedge clk);
        check("t4_one_transfer", hs_count - hs0, 1);
        check("t4_valid_low", data_valid, 0);

        // Asynchronous reset during bit 7 trial
        an_fix_en = 1'b0; tv_mode = 0; rdy_mode = 0;
        n0 = ptv_log.size();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk); #1;
            if (m_k == 9) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail("t5_bit7");
        #1 rst_n = 1'b0;
        #1;
        check("t5_phase", phase, 16'h0000);
        check("t5_busy", busy, 0);
        check("t5_dac", dac_code, 16'h0000);
        check("t5_dout", digital_out, 16'h0000);
        check("t5_valid", data_valid, 0);
        check("t5_sh", sample_hold, 0);
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        n0 = ptv_log.size();
        repeat (10) @(negedge clk);
        check("t5_stays_idle", busy, 0);
        check("t5_no_ptv", ptv_log.size(), n0);

        // Fully random traffic
        for (int n = 0; n < 600; n++) begin
            @(posedge clk); #1 start = ($urandom_range(3) == 0);
        end
        start = 1'b0;
        rdy_mode = 1;
        wait_idle("t6_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
